// File: rtl/pong_pkg.sv
// Shared types and constants for the pong frame drawing path.
package pong_pkg;

    // Frame sequencer states, in sequence order
    typedef enum logic [3:0] {
        S_IDLE,
        S_LATCH,
        S_E_LEFT,
        S_E_RIGHT,
        S_E_BALL,
        S_D_LEFT,
        S_D_RIGHT,
        S_D_BALL,
        S_DONE
    } state_t;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;
    localparam logic [2:0] COLOUR_WHITE = 3'b111;

    localparam int SCR_W = 160;
    localparam int SCR_H = 120;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rect_scanner.sv
// Row-major rectangle walker: column offset fastest, then row. Wraps to the
// origin after the last pixel so back-to-back rectangles need no idle cycle.
module rect_scanner #(
    parameter int W  = 2,
    parameter int H  = 16,
    parameter int CW = $clog2(W + 1),
    parameter int RW = $clog2(H + 1)
) (
    input  logic          CLOCK_50,
    input  logic          resetn,
    input  logic          start,
    input  logic [CW-1:0] w,
    input  logic [RW-1:0] h,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last
);

    logic row_end;

    assign row_end = (col == w - CW'(1));
    assign last    = row_end && (row == h - RW'(1));

    // Hold at origin while start is high, otherwise step one pixel per clock
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            col <= '0;
            row <= '0;
        end else if (start) begin
            col <= '0;
            row <= '0;
        end else if (row_end) begin
            col <= '0;
            row <= last ? '0 : row + RW'(1);
        end else begin
            col <= col + CW'(1);
        end
    end

endmodule

// File: rtl/pong_draw_sequencer.sv
// Per-frame owner of the VGA plot port: erases the previous paddles and ball,
// then draws them at freshly latched positions, one pixel per clock.
module pong_draw_sequencer #(
    parameter int PADDLE_W = 2,
    parameter int PADDLE_H = 16,
    parameter int BALL_SZ  = 2,
    parameter int LEFT_X   = 0,
    parameter int RIGHT_X  = 118,
    parameter int SCR_W    = pong_pkg::SCR_W,
    parameter int SCR_H    = pong_pkg::SCR_H
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic [6:0] left_y,
    input  logic [6:0] right_y,
    input  logic [7:0] ball_x,
    input  logic [6:0] ball_y,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    import pong_pkg::*;

    localparam int W_MAX = imax(PADDLE_W, BALL_SZ);
    localparam int H_MAX = imax(PADDLE_H, BALL_SZ);
    localparam int CW    = $clog2(W_MAX + 1);
    localparam int RW    = $clog2(H_MAX + 1);

    localparam logic [8:0] X_LIM = 9'(SCR_W);
    localparam logic [7:0] Y_LIM = 8'(SCR_H);
    localparam logic [7:0] LX    = 8'(LEFT_X);
    localparam logic [7:0] RX    = 8'(RIGHT_X);

    state_t state, state_nx;

    // Positions: nxt_* is this frame's target, cur_* is what is on screen
    logic [6:0] nxt_left, nxt_right, nxt_ball_y;
    logic [7:0] nxt_ball_x;
    logic [6:0] cur_left, cur_right, cur_ball_y;
    logic [7:0] cur_ball_x;
    logic       drawn;

    logic          scan_clr, active;
    logic [CW-1:0] col, rw;
    logic [RW-1:0] row, rh;
    logic          last;

    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [2:0] pix_colour;
    logic [8:0] px;
    logic [7:0] py;
    logic       visible;

    rect_scanner #(.W(W_MAX), .H(H_MAX), .CW(CW), .RW(RW)) u_scan (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .start    (scan_clr),
        .w        (rw),
        .h        (rh),
        .col      (col),
        .row      (row),
        .last     (last)
    );

    // State register
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nx;
    end

    // Next-state: rectangle states advance on their last pixel
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (frame_tick) state_nx = S_LATCH;
            S_LATCH:   state_nx = drawn ? S_E_LEFT : S_D_LEFT;
            S_E_LEFT:  if (last) state_nx = S_E_RIGHT;
            S_E_RIGHT: if (last) state_nx = S_E_BALL;
            S_E_BALL:  if (last) state_nx = S_D_LEFT;
            S_D_LEFT:  if (last) state_nx = S_D_RIGHT;
            S_D_RIGHT: if (last) state_nx = S_D_BALL;
            S_D_BALL:  if (last) state_nx = S_DONE;
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // FSM outputs: status flags and scanner control
    always_comb begin
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        active   = 1'b0;
        case (state)
            S_E_LEFT, S_E_RIGHT, S_E_BALL,
            S_D_LEFT, S_D_RIGHT, S_D_BALL: active = 1'b1;
            default:                       active = 1'b0;
        endcase
        scan_clr = !active;
    end

    // Pick the rectangle origin, size and colour for the current state
    always_comb begin
        base_x     = '0;
        base_y     = '0;
        rw         = CW'(PADDLE_W);
        rh         = RW'(PADDLE_H);
        pix_colour = COLOUR_BLACK;
        case (state)
            S_E_LEFT:  begin base_x = LX; base_y = cur_left; end
            S_E_RIGHT: begin base_x = RX; base_y = cur_right; end
            S_E_BALL:  begin
                base_x = cur_ball_x; base_y = cur_ball_y;
                rw = CW'(BALL_SZ); rh = RW'(BALL_SZ);
            end
            S_D_LEFT:  begin base_x = LX; base_y = nxt_left; pix_colour = COLOUR_WHITE; end
            S_D_RIGHT: begin base_x = RX; base_y = nxt_right; pix_colour = COLOUR_WHITE; end
            S_D_BALL:  begin
                base_x = nxt_ball_x; base_y = nxt_ball_y;
                rw = CW'(BALL_SZ); rh = RW'(BALL_SZ);
                pix_colour = COLOUR_WHITE;
            end
            default: ;
        endcase
    end

    // One extra bit on each axis so off-screen pixels never wrap back on
    assign px      = {1'b0, base_x} + 9'(col);
    assign py      = {1'b0, base_y} + 8'(row);
    assign visible = (px < X_LIM) && (py < Y_LIM);

    // Position latches: capture at LATCH, commit to on-screen copy at DONE
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            nxt_left   <= '0;
            nxt_right  <= '0;
            nxt_ball_x <= '0;
            nxt_ball_y <= '0;
            cur_left   <= '0;
            cur_right  <= '0;
            cur_ball_x <= '0;
            cur_ball_y <= '0;
            drawn      <= 1'b0;
        end else if (state == S_LATCH) begin
            nxt_left   <= left_y;
            nxt_right  <= right_y;
            nxt_ball_x <= ball_x;
            nxt_ball_y <= ball_y;
        end else if (state == S_DONE) begin
            cur_left   <= nxt_left;
            cur_right  <= nxt_right;
            cur_ball_x <= nxt_ball_x;
            cur_ball_y <= nxt_ball_y;
            drawn      <= 1'b1;
        end
    end

    // Registered plot port and dropped-tick pulse
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            x       <= '0;
            y       <= '0;
            colour  <= COLOUR_BLACK;
            plot    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            x       <= px[7:0];
            y       <= py[6:0];
            colour  <= pix_colour;
            plot    <= active && visible;
            overrun <= frame_tick && (state != S_IDLE);
        end
    end

endmodule

// File: tb/tb_pong_draw_sequencer.sv
// Scoreboard bench: each frame pushes its expected pixel stream, a negedge
// monitor pops and compares on every plot strobe.
module tb_pong_draw_sequencer;

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic       frame_tick;
    logic [6:0] left_y, right_y, ball_y;
    logic [7:0] ball_x;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done, overrun;

    pong_draw_sequencer dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .frame_tick (frame_tick),
        .left_y     (left_y),
        .right_y    (right_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [17:0] sb[$];
    int n_plot, first_plot_cyc, done_cyc, ovr_cyc;

    // Model of what is on screen
    bit drawn_m = 0;
    int cl = 0, cr = 0, cbx = 0, cby = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_rect(input int bx, input int by, input int w, input int h,
                             input logic [2:0] c);
        for (int r = 0; r < h; r++)
            for (int k = 0; k < w; k++)
                if (bx + k < 160 && by + r < 120)
                    sb.push_back({8'(bx + k), 7'(by + r), c});
    endtask

    task automatic push_frame(input int l, input int r, input int bx, input int by,
                              input logic [2:0] c);
        push_rect(0, l, 2, 16, c);
        push_rect(118, r, 2, 16, c);
        push_rect(bx, by, 2, 2, c);
    endtask

    // Cycle counter, advanced on the active edge
    initial forever begin
        @(posedge CLOCK_50);
        cyc++;
    end

    // Monitor: compare every plotted pixel against the scoreboard head
    initial forever begin
        @(negedge CLOCK_50);
        if (resetn) begin
            if (plot) begin
                n_plot++;
                if (first_plot_cyc < 0) first_plot_cyc = cyc;
                if (sb.size() == 0) chk("unexpected_plot", {x, y, colour}, 0);
                else chk("pixel_xyc", {x, y, colour}, sb.pop_front());
            end
            if (done) done_cyc = cyc;
            if (overrun) ovr_cyc = cyc;
        end
    end

    task automatic do_frame(input string tag, input int l, input int r, input int bx,
                            input int by, input int ovr_at, input int chg_at,
                            input int chg_val, input int rst_at);
        int t0, lat, nexp;
        @(posedge CLOCK_50);
        #1;
        left_y = 7'(l); right_y = 7'(r); ball_x = 8'(bx); ball_y = 7'(by);
        sb.delete();
        if (drawn_m) push_frame(cl, cr, cbx, cby, 3'b000);
        push_frame(l, r, bx, by, 3'b111);
        nexp = sb.size();
        lat = drawn_m ? 138 : 70;
        n_plot = 0; first_plot_cyc = -1; done_cyc = -1; ovr_cyc = -1;
        frame_tick = 1'b1;
        t0 = cyc;
        @(posedge CLOCK_50);
        #1;
        while (done_cyc < 0 && cyc - t0 < 400) begin
            frame_tick = (cyc - t0 == ovr_at);
            if (cyc - t0 == chg_at) right_y = 7'(chg_val);
            if (cyc - t0 == rst_at) begin
                chk({tag, "_busy_pre_rst"}, busy, 1);
                #2 resetn = 1'b0;
                #1;
                chk({tag, "_rst_plot"}, plot, 0);
                chk({tag, "_rst_busy"}, busy, 0);
                chk({tag, "_rst_done"}, done, 0);
                chk({tag, "_rst_xyc"}, {x, y, colour}, 0);
                sb.delete();
                repeat (2) @(posedge CLOCK_50);
                #1 resetn = 1'b1;
                frame_tick = 1'b0;
                drawn_m = 0; cl = 0; cr = 0; cbx = 0; cby = 0;
                return;
            end
            @(posedge CLOCK_50);
            #1;
        end
        frame_tick = 1'b0;
        chk({tag, "_done_latency"}, (done_cyc < 0) ? -1 : done_cyc - t0, lat);
        chk({tag, "_first_plot_latency"}, first_plot_cyc - t0, 3);
        chk({tag, "_plot_count"}, n_plot, nexp);
        chk({tag, "_sb_left"}, sb.size(), 0);
        if (ovr_at > 0) chk({tag, "_overrun_cycle"}, ovr_cyc - t0, ovr_at + 1);
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk({tag, "_idle_after"}, busy, 0);
        drawn_m = 1; cl = l; cr = r; cbx = bx; cby = by;
    endtask

    initial begin
        resetn = 1'b1; frame_tick = 1'b0;
        left_y = '0; right_y = '0; ball_x = '0; ball_y = '0;
        #3 resetn = 1'b0;
        #1;
        chk("reset_plot", plot, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_xyc", {x, y, colour}, 0);
        repeat (3) @(posedge CLOCK_50);
        #1 resetn = 1'b1;

        // first frame: nothing to erase
        do_frame("first", 54, 54, 80, 60, -1, -1, 0, -1);
        // left paddle moves: erase then draw
        do_frame("move", 40, 54, 80, 60, -1, -1, 0, -1);
        // ball in bottom-right corner: three ball pixels clipped
        do_frame("clip", 40, 54, 159, 119, -1, -1, 0, -1);
        // extra tick mid-sequence is dropped and flagged
        do_frame("ovr", 40, 54, 80, 60, 20, -1, 0, -1);
        // right_y changes mid-frame; takes effect only next frame
        do_frame("chg", 40, 54, 80, 60, -1, 30, 10, -1);
        do_frame("chg_next", 40, 10, 80, 60, -1, -1, 0, -1);
        // reset during D_RIGHT, then a clean draw without erase
        do_frame("rst", 20, 30, 50, 50, -1, -1, 0, 110);
        do_frame("post_rst", 20, 30, 50, 50, -1, -1, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d want finish", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
